// File: rtl/game_round_sequencer.sv
// Round sequencer for a reaction game: requests a random LED, waits for the
// player's press or a timeout, scores the round and repeats for N_ROUNDS rounds.
module game_round_sequencer #(
    parameter int N_ROUNDS       = 8,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [4:0] botoes,
    input  logic [2:0] led_sorteado,
    input  logic       led_valido,
    output logic       gerar_jogada,
    output logic       apagar,
    output logic [3:0] rodada,
    output logic [3:0] acertos,
    output logic [3:0] erros,
    output logic       ultimo_acerto,
    output logic       pronto,
    output logic [2:0] db_estado
);

    localparam int              TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      R_LAST = 4'(N_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        GERA          = 3'd1,
        ESPERA_LED    = 3'd2,
        ESPERA_JOGADA = 3'd3,
        AVALIA        = 3'd4,
        PROXIMA       = 3'd5,
        FIM           = 3'd6
    } state_t;

    state_t        state, next;
    logic [4:0]    botoes_q;
    logic [2:0]    led_idx;
    logic [TW-1:0] timer;
    logic          hit_q;

    logic [4:0]    rise;
    logic          multi;
    logic          start_game, load_led, tick_timer, set_result, result_hit;
    logic          count_result, adv_round;

    // A press is a 0->1 edge against last cycle's sample; the sampler runs in
    // every state so buttons held on entry never look like fresh presses.
    assign rise  = botoes & ~botoes_q;
    assign multi = |(rise & (rise - 5'd1));

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next         = state;
        gerar_jogada = 1'b0;
        apagar       = 1'b1;
        pronto       = 1'b0;
        start_game   = 1'b0;
        load_led     = 1'b0;
        tick_timer   = 1'b0;
        set_result   = 1'b0;
        result_hit   = 1'b0;
        count_result = 1'b0;
        adv_round    = 1'b0;
        case (state)
            IDLE: begin
                if (iniciar) begin
                    start_game = 1'b1;
                    next       = GERA;
                end
            end
            GERA: begin
                gerar_jogada = 1'b1;
                next         = ESPERA_LED;
            end
            ESPERA_LED: begin
                apagar = 1'b0;
                if (led_valido) begin
                    load_led = 1'b1;
                    // Out-of-range index cannot be hit: score a miss right away.
                    if (led_sorteado > 3'd4) begin
                        set_result = 1'b1;
                        next       = AVALIA;
                    end else begin
                        next = ESPERA_JOGADA;
                    end
                end
            end
            ESPERA_JOGADA: begin
                apagar = 1'b0;
                if (|rise) begin
                    set_result = 1'b1;
                    result_hit = !multi && (rise == (5'd1 << led_idx));
                    next       = AVALIA;
                end else if (timer == T_LAST) begin
                    set_result = 1'b1;
                    next       = AVALIA;
                end else begin
                    tick_timer = 1'b1;
                end
            end
            AVALIA: begin
                count_result = 1'b1;
                next         = PROXIMA;
            end
            PROXIMA: begin
                if (rodada == R_LAST) begin
                    next = FIM;
                end else begin
                    adv_round = 1'b1;
                    next      = GERA;
                end
            end
            FIM: begin
                pronto = 1'b1;
                if (iniciar) begin
                    start_game = 1'b1;
                    next       = GERA;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            botoes_q      <= '0;
            led_idx       <= '0;
            timer         <= '0;
            hit_q         <= 1'b0;
            rodada        <= '0;
            acertos       <= '0;
            erros         <= '0;
            ultimo_acerto <= 1'b0;
        end else begin
            botoes_q <= botoes;
            if (start_game) begin
                rodada        <= '0;
                acertos       <= '0;
                erros         <= '0;
                ultimo_acerto <= 1'b0;
            end
            if (load_led) begin
                led_idx <= led_sorteado;
                timer   <= '0;
            end
            if (tick_timer) timer <= timer + TW'(1);
            if (set_result) hit_q <= result_hit;
            if (count_result) begin
                ultimo_acerto <= hit_q;
                if (hit_q) begin
                    if (acertos != 4'hF) acertos <= acertos + 4'd1;
                end else begin
                    if (erros != 4'hF) erros <= erros + 4'd1;
                end
            end
            if (adv_round) rodada <= rodada + 4'd1;
        end
    end

    assign db_estado = state;

endmodule

// File: tb/tb_game_round_sequencer.sv
// Directed bench for game_round_sequencer with N_ROUNDS=3, TIMEOUT_CYCLES=20.
module tb_game_round_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic [4:0] botoes;
    logic [2:0] led_sorteado;
    logic       led_valido;
    logic       gerar_jogada, apagar, ultimo_acerto, pronto;
    logic [3:0] rodada, acertos, erros;
    logic [2:0] db_estado;

    int errors = 0;
    int checks = 0;

    game_round_sequencer #(.N_ROUNDS(3), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .led_sorteado(led_sorteado), .led_valido(led_valido),
        .gerar_jogada(gerar_jogada), .apagar(apagar), .rodada(rodada),
        .acertos(acertos), .erros(erros), .ultimo_acerto(ultimo_acerto),
        .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // From GERA: advance to ESPERA_LED, present the LED index, land in the next state.
    task automatic play_led(input logic [2:0] idx);
        tick();
        led_sorteado = idx;
        led_valido   = 1'b1;
        tick();
        led_valido   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; iniciar = 1'b0; botoes = '0; led_sorteado = '0; led_valido = 1'b0;
        tick(2);
        chk("rst_state",   db_estado, 0);
        chk("rst_apagar",  apagar, 1);
        chk("rst_gerar",   gerar_jogada, 0);
        chk("rst_rodada",  rodada, 0);
        chk("rst_acertos", acertos, 0);
        chk("rst_erros",   erros, 0);
        chk("rst_pronto",  pronto, 0);
        reset = 1'b1;
        tick();

        // Game 1, round 0: hit on LED 2
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("g1_gerar_on", gerar_jogada, 1);
        chk("g1_gera_st",  db_estado, 1);
        tick();
        chk("g1_gerar_off", gerar_jogada, 0);
        chk("g1_espled",    db_estado, 2);
        chk("g1_apagar0",   apagar, 0);
        led_sorteado = 3'd2; led_valido = 1'b1;
        tick();
        led_valido = 1'b0;
        chk("g1_espjog", db_estado, 3);
        botoes = 5'b00100;
        tick();
        chk("g1_avalia",    db_estado, 4);
        chk("g1_lat1_acc",  acertos, 0);
        botoes = '0;
        tick();
        chk("g1_hit_acc",  acertos, 1);
        chk("g1_hit_ult",  ultimo_acerto, 1);
        chk("g1_prox_apg", apagar, 1);
        tick();
        chk("g1_rodada1", rodada, 1);
        chk("g1_gera2",   gerar_jogada, 1);

        // Round 1: wrong single button
        play_led(3'd4);
        botoes = 5'b00001;
        tick();
        botoes = '0;
        tick();
        chk("g1_wrong_err", erros, 1);
        chk("g1_wrong_ult", ultimo_acerto, 0);
        tick();

        // Round 2: two buttons rising together
        play_led(3'd0);
        botoes = 5'b00011;
        tick();
        botoes = '0;
        tick();
        chk("g1_multi_err", erros, 2);
        chk("g1_multi_acc", acertos, 1);
        tick();
        chk("g1_fim_st",   db_estado, 6);
        chk("g1_pronto",   pronto, 1);
        chk("g1_total",    acertos + erros, 3);
        tick(3);
        chk("g1_fim_hold", db_estado, 6);

        // Restart from FIM
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("g2_gerar",   gerar_jogada, 1);
        chk("g2_clr_acc", acertos, 0);
        chk("g2_clr_err", erros, 0);
        chk("g2_pronto0", pronto, 0);

        // Game 2, round 0: timeout after 20 cycles in ESPERA_JOGADA
        play_led(3'd3);
        tick(19);
        chk("g2_to_wait", db_estado, 3);
        tick();
        chk("g2_to_av", db_estado, 4);
        tick();
        chk("g2_to_err", erros, 1);
        tick();

        // Round 1: press lands on the last timer cycle and wins
        play_led(3'd1);
        tick(19);
        botoes = 5'b00010;
        tick();
        botoes = '0;
        chk("g2_late_av", db_estado, 4);
        tick();
        chk("g2_late_acc", acertos, 1);
        chk("g2_late_err", erros, 1);
        tick();

        // Round 2: button held across entry does not count
        botoes = 5'b00010;
        play_led(3'd1);
        tick(3);
        chk("g2_held_st",  db_estado, 3);
        chk("g2_held_acc", acertos, 1);
        botoes = '0;
        tick();
        botoes = 5'b00010;
        tick();
        botoes = '0;
        tick();
        chk("g2_repress_acc", acertos, 2);
        tick();
        chk("g2_fim", db_estado, 6);

        // Game 3: out-of-range index, iniciar ignored mid-round, reset mid-round
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        tick();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("g3_ign_st", db_estado, 2);
        led_sorteado = 3'd7; led_valido = 1'b1;
        tick();
        led_valido = 1'b0;
        chk("g3_bad_av", db_estado, 4);
        tick();
        chk("g3_bad_err", erros, 1);
        tick();
        play_led(3'd3);
        botoes = 5'b01000;
        tick();
        botoes = '0;
        tick(2);
        chk("g3_r2", rodada, 2);
        play_led(3'd2);
        chk("g3_pre_st",  db_estado, 3);
        chk("g3_pre_ult", ultimo_acerto, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("g3_rst_st",   db_estado, 0);
        chk("g3_rst_rod",  rodada, 0);
        chk("g3_rst_acc",  acertos, 0);
        chk("g3_rst_err",  erros, 0);
        chk("g3_rst_ult",  ultimo_acerto, 0);
        chk("g3_rst_apg",  apagar, 1);
        chk("g3_rst_gera", gerar_jogada, 0);
        tick();
        chk("g3_idle_stay", db_estado, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_round_sequencer.md
GAME_ROUND_SEQUENCER -- requirements
Module: game_round_sequencer

Interface
REQ-001 Parameter N_ROUNDS, default 8, SHALL set the number of rounds per game (legal range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 50_000_000, SHALL set the player response window in clock cycles (1 s at 50 MHz).
REQ-003 Ports SHALL be, one per line:
 clock  in  1  system clock, 50 MHz, all logic on rising edge
 reset  in  1  synchronous, active-low reset
 iniciar  in  1  start-game request, sampled every cycle
 botoes  in  5  player buttons, already synchronised, bit i = LED i
 led_sorteado  in  3  index 0..4 of the LED lit by the random LED controller
 led_valido  in  1  random LED controller has loaded the new frame
 gerar_jogada  out  1  one-cycle request to the random LED controller
 apagar  out  1  level: LEDs must be dark
 rodada  out  4  current round number, 0-based
 acertos  out  4  correct-press count
 erros  out  4  miss count (wrong, multiple, or timeout)
 ultimo_acerto  out  1  result of last completed round
 pronto  out  1  game finished
 db_estado  out  3  current state encoding

Function
REQ-004 States SHALL be IDLE=0, GERA=1, ESPERA_LED=2, ESPERA_JOGADA=3, AVALIA=4, PROXIMA=5, FIM=6; db_estado SHALL equal the current encoding.
REQ-005 IDLE: apagar=1; iniciar=1 -> clear rodada, acertos, erros, ultimo_acerto; next state GERA.
REQ-006 GERA: gerar_jogada=1 for exactly that one cycle; next state ESPERA_LED unconditionally.
REQ-007 ESPERA_LED: remain until led_valido=1; then latch led_sorteado, clear the response timer, go to ESPERA_JOGADA.
REQ-008 A latched index of 5..7 SHALL count as an error and skip ESPERA_JOGADA (go directly to AVALIA with a miss).
REQ-009 ESPERA_JOGADA: timer increments every cycle; a button press is a 0->1 transition versus the previous-cycle registered value of botoes.
REQ-010 Press edges are evaluated in the cycle they occur:
 - exactly one bit rising, and it equals the latched index -> hit
 - exactly one bit rising, wrong index -> miss
 - two or more bits rising in the same cycle -> miss
REQ-011 Buttons already held on entry to ESPERA_JOGADA SHALL NOT count as presses; the edge register keeps sampling in all states.
REQ-012 If the timer reaches TIMEOUT_CYCLES-1 with no edge -> miss; an edge in that same cycle takes priority over the timeout.
REQ-013 Any hit or miss SHALL transition to AVALIA on the next edge.
REQ-014 AVALIA (one cycle): increment acertos or erros; set ultimo_acerto; apagar=1.
REQ-015 PROXIMA (one cycle): if rodada == N_ROUNDS-1 -> FIM, else increment rodada -> GERA; apagar=1.
REQ-016 FIM: pronto=1, apagar=1, all counters hold; iniciar=1 -> same actions as REQ-005 and go to GERA.
REQ-017 iniciar SHALL be ignored in all states except IDLE and FIM.
REQ-018 apagar SHALL be 0 only in ESPERA_LED and ESPERA_JOGADA.
REQ-019 acertos + erros SHALL equal the number of completed rounds at all times; neither counter wraps (max N_ROUNDS).
REQ-020 Latency: iniciar high in IDLE -> gerar_jogada high exactly 1 cycle later; correct press edge -> acertos updated 2 cycles later.

Reset
REQ-021 reset=0 at a rising edge SHALL force IDLE and set gerar_jogada=0, apagar=1, rodada=0, acertos=0, erros=0, ultimo_acerto=0, pronto=0, db_estado=0, timer=0, edge register=0, from any state, including mid-round.

Verification (N_ROUNDS=3, TIMEOUT_CYCLES=20)
REQ-022 Reset then iniciar pulse; led_valido with led_sorteado=2; press botoes=00100 -> single gerar_jogada pulse, acertos=1, ultimo_acerto=1, rodada=1.
REQ-023 led_sorteado=4, press botoes=00001 -> erros=1, ultimo_acerto=0; next round: press 00011 in one cycle -> erros=2.
REQ-024 No press for 20 cycles after led_valido -> miss on cycle 20; press in cycle 19 (timer=19) -> evaluated as press, not timeout.
REQ-025 Hold botoes=00010 from before ESPERA_JOGADA, led_sorteado=1 -> no hit until released and re-pressed.
REQ-026 Three rounds complete -> pronto=1, db_estado=6, acertos+erros=3; iniciar -> counters cleared, gerar_jogada pulses.
REQ-027 reset=0 while in ESPERA_JOGADA at rodada=2 -> next cycle all outputs at REQ-021 values; iniciar during ESPERA_LED -> no effect.
